montacargas: RTL and testbench
==============================

// Module: montacargas
// PURPOSE
// - Controller for a 3-floor freight lift: latches a floor request from the call buttons and drives a 2-bit motor command up/down.
// - Stops when the target floor's limit switch closes; shows the current floor on one common-cathode 7-segment digit.
// - Top-level leaf block; buttons and limit switches come straight from board pins (asynchronous).
// PARAMETERS
// - TIMEOUT_CYCLES  1000  max cycles in UP/DOWN before fault (used only with MOVE_TIMEOUT_EN)
// PORTS
// - clk        in   1  system clock, rising edge
// - rst        in   1  reset, asynchronous, active-low
// - P1,P2,P3   in   1  call buttons, active-high, any length >= 3 cycles
// - Fc1,Fc2,Fc3 in  1  floor limit switches, active-high (1 = cab at that floor)
// - motor      out  2  00 stop, 01 up, 10 down; 11 never driven
// - disp_7seg  out  7  segments {a,b,c,d,e,f,g}, active-high
// - COMC       out  1  digit common enable, 1 = digit lit
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE, floor_r=0 (unknown), target=0, motor=00, disp_7seg=0000000, COMC=0.
// - After reset release COMC=1 permanently; all outputs registered.
// - Inputs pass through 2-flop synchronisers; FSM acts on synced values, so motor changes on the 3rd rising edge after an input change.
// - floor_r: updated to n when exactly one synced Fcn is 1; holds last value when none or >1 active.
// - Display: floor 1=0110000, 2=1101101, 3=1111001, unknown=0000001 (dash).
// - States: IDLE, UP, DOWN (plus FAULT with option).
// - IDLE: button request with priority P1>P2>P3; ignored while floor_r=0.
// -   request floor > floor_r -> target=req, UP, motor=01.
// -   request floor < floor_r -> target=req, DOWN, motor=10.
// -   request == floor_r -> stay IDLE, motor=00.
// - UP/DOWN: all buttons ignored; target fixed until arrival.
// -   synced Fc of target = 1 -> IDLE, motor=00 (same edge).
// -   intermediate floor switch passes: only floor_r/display update, motor unchanged.
// - Safety: UP with synced Fc3=1, or DOWN with Fc1=1 -> IDLE, motor=00, even if target differs.
// - Simultaneous buttons: highest priority wins, others dropped (not queued).
// - Reset mid-travel: motor=00 immediately (async); floor_r unknown until a switch is seen.
// CONFIGURATION
// - MOVE_TIMEOUT_EN defined: cycle counter runs in UP/DOWN, cleared on entry;
//   reaching TIMEOUT_CYCLES -> FAULT: motor=00, disp_7seg=1001111 ('E').
//   FAULT left only by reset.
// - MOVE_TIMEOUT_EN undefined: no counter, no FAULT state; UP/DOWN last indefinitely.
// TESTING
// - Reset with Fc1=1 -> motor=00, COMC=0 during reset; after release disp=0110000, COMC=1.
// - At floor 1, pulse P3 -> motor=01; Fc2 pulse passes -> disp=1101101, motor=01.
//   Fc3=1 -> motor=00, disp=1111001.
// - At floor 3, pulse P1 -> motor=10 through Fc2; Fc1=1 -> motor=00, disp=0110000.
// - Single floor: 1->2 via P2 (motor=01 then 00 at Fc2); 2->1 via P1 (motor=10 then 00 at Fc1).
// - At floor 1, pulse P1 -> motor stays 00; P1+P3 together at floor 2 -> motor=10 (P1 wins).
// - No switch after reset, press P2 -> motor stays 00, disp=0000001.
//   With MOVE_TIMEOUT_EN: hold no Fc after P3 -> motor=00, disp=1001111 after TIMEOUT_CYCLES.

Source files
------------

// File: rtl/montacargas.sv
// ---------------------------------------------------------------------------
// montacargas -- controller for a 3-floor freight lift.
//
// The controller latches one floor request from the call buttons and drives
// the motor up or down. It stops when the limit switch of the target floor
// closes. It shows the current floor on one common-cathode 7-segment digit.
//
// Parameters
//   TIMEOUT_CYCLES : maximum number of cycles in UP/DOWN before a fault.
//                    Only used when MOVE_TIMEOUT_EN is defined.
//
// Ports
//   clk         : system clock, rising edge
//   rst         : asynchronous reset, active-low
//   P1,P2,P3    : call buttons, active-high, asynchronous
//   Fc1,Fc2,Fc3 : floor limit switches, active-high, asynchronous
//   motor       : 00 stop, 01 up, 10 down
//   disp_7seg   : segments {a,b,c,d,e,f,g}, active-high
//   COMC        : digit common enable, 1 = digit lit
//
// Optional build macro
//   MOVE_TIMEOUT_EN : adds a travel-time watchdog and a FAULT state.
//                     FAULT shows 'E' and is left only by reset.
// ---------------------------------------------------------------------------
module montacargas #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       P1,
  input  logic       P2,
  input  logic       P3,
  input  logic       Fc1,
  input  logic       Fc2,
  input  logic       Fc3,
  output logic [1:0] motor,
  output logic [6:0] disp_7seg,
  output logic       COMC
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UP    = 2'd1,
    DOWN  = 2'd2
`ifdef MOVE_TIMEOUT_EN
    , FAULT = 2'd3
`endif
  } state_t;

  localparam logic [6:0] SEG_E = 7'b1001111;

  // Two-flop synchronisers. Index 0 is floor 1.
  logic [2:0] btn_p0, btn_p1;
  logic [2:0] fc_p0, fc_p1;

  state_t     state_r, state_nxt;
  logic [1:0] floor_r, floor_nxt;
  logic [1:0] target_r, target_nxt;
  logic [1:0] req;
  logic [1:0] motor_nxt;
  logic [6:0] disp_nxt;
  logic       timeout;

  function automatic logic [6:0] seg_of(input logic [1:0] fl);
    case (fl)
      2'd1:    seg_of = 7'b0110000;
      2'd2:    seg_of = 7'b1101101;
      2'd3:    seg_of = 7'b1111001;
      default: seg_of = 7'b0000001;   // floor unknown: dash
    endcase
  endfunction

  function automatic logic fc_at(input logic [1:0] fl, input logic [2:0] fc);
    case (fl)
      2'd1:    fc_at = fc[0];
      2'd2:    fc_at = fc[1];
      2'd3:    fc_at = fc[2];
      default: fc_at = 1'b0;
    endcase
  endfunction

  // ---- synchroniser stage ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_p0 <= '0;
      btn_p1 <= '0;
      fc_p0  <= '0;
      fc_p1  <= '0;
    end else begin
      btn_p0 <= {P3, P2, P1};
      btn_p1 <= btn_p0;
      fc_p0  <= {Fc3, Fc2, Fc1};
      fc_p1  <= fc_p0;
    end
  end

`ifdef MOVE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_r;

  // The counter is held at zero while idle, so every trip starts from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_r <= '0;
    else if (state_r == UP || state_r == DOWN)
      cnt_r <= cnt_r + 1'b1;
    else
      cnt_r <= '0;
  end

  assign timeout = (cnt_r == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // ---- state register stage ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      floor_r   <= 2'd0;
      target_r  <= 2'd0;
      motor     <= 2'b00;
      disp_7seg <= 7'b0000000;
      COMC      <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      floor_r   <= floor_nxt;
      target_r  <= target_nxt;
      motor     <= motor_nxt;
      disp_7seg <= disp_nxt;
      COMC      <= 1'b1;
    end
  end

  // Floor tracking. The floor is updated only when exactly one switch is active.
  always_comb begin
    floor_nxt = floor_r;
    case (fc_p1)
      3'b001:  floor_nxt = 2'd1;
      3'b010:  floor_nxt = 2'd2;
      3'b100:  floor_nxt = 2'd3;
      default: floor_nxt = floor_r;
    endcase
  end

  // Button priority: P1 > P2 > P3. Any lower-priority request is dropped.
  always_comb begin
    req = 2'd0;
    if (btn_p1[0])      req = 2'd1;
    else if (btn_p1[1]) req = 2'd2;
    else if (btn_p1[2]) req = 2'd3;
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt  = state_r;
    target_nxt = target_r;
    case (state_r)
      IDLE: begin
        if (floor_r != 2'd0 && req != 2'd0) begin
          if (req > floor_r) begin
            target_nxt = req;
            state_nxt  = UP;
          end else if (req < floor_r) begin
            target_nxt = req;
            state_nxt  = DOWN;
          end
        end
      end
      // An end-of-shaft switch also stops the cab, whatever the target is.
      UP: begin
        if (fc_at(target_r, fc_p1) || fc_p1[2]) state_nxt = IDLE;
`ifdef MOVE_TIMEOUT_EN
        else if (timeout)                       state_nxt = FAULT;
`endif
      end
      DOWN: begin
        if (fc_at(target_r, fc_p1) || fc_p1[0]) state_nxt = IDLE;
`ifdef MOVE_TIMEOUT_EN
        else if (timeout)                       state_nxt = FAULT;
`endif
      end
`ifdef MOVE_TIMEOUT_EN
      FAULT: state_nxt = FAULT;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // ---- registered-output decode ----
  // The outputs are decoded from the next state, so the motor and display
  // change on the same edge as the state.
  always_comb begin
    motor_nxt = 2'b00;
    disp_nxt  = seg_of(floor_nxt);
    case (state_nxt)
      UP:      motor_nxt = 2'b01;
      DOWN:    motor_nxt = 2'b10;
`ifdef MOVE_TIMEOUT_EN
      FAULT:   disp_nxt  = SEG_E;
`endif
      default: motor_nxt = 2'b00;
    endcase
  end

  // Keeps the 'E' pattern and the timeout flag referenced in the default build.
  logic unused_ok;
  assign unused_ok = ^{SEG_E, timeout};

endmodule

// File: tb/tb_montacargas.sv
// ---------------------------------------------------------------------------
// tb_montacargas -- directed, table-driven bench for the freight lift
// controller.
//
// Each table row holds the button and switch levels and the expected motor
// and display values. A row is held for four clock cycles before its checks.
// Hand-written sequences cover reset, the exact input-to-motor latency, an
// asynchronous reset while travelling and the optional timeout.
// ---------------------------------------------------------------------------
module tb_montacargas;

  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] SD = 7'b0000001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       P1 = 1'b0, P2 = 1'b0, P3 = 1'b0;
  logic       Fc1 = 1'b0, Fc2 = 1'b0, Fc3 = 1'b0;
  logic [1:0] motor;
  logic [6:0] disp_7seg;
  logic       COMC;

  int total = 0;
  int bad   = 0;

  montacargas #(.TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst),
    .P1(P1), .P2(P2), .P3(P3),
    .Fc1(Fc1), .Fc2(Fc2), .Fc3(Fc3),
    .motor(motor), .disp_7seg(disp_7seg), .COMC(COMC)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] p;     // {P3,P2,P1}
    logic [2:0] fc;    // {Fc3,Fc2,Fc1}
    logic [1:0] motor;
    logic [6:0] disp;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Move to 1 ns after the n-th rising edge from now.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] p, input logic [2:0] fc);
    {P3, P2, P1}    = p;
    {Fc3, Fc2, Fc1} = fc;
  endtask

  task automatic add(input logic [2:0] p, input logic [2:0] fc,
                     input logic [1:0] m, input logic [6:0] d);
    vec_t v;
    v.p = p; v.fc = fc; v.motor = m; v.disp = d;
    vt.push_back(v);
  endtask

  initial begin
    // Reset with the cab at floor 1.
    drive(3'b000, 3'b001);
    rst = 1'b0;
    cyc(3);
    check("rst_motor", 32'(motor), 32'(2'b00));
    check("rst_disp",  32'(disp_7seg), 32'(7'b0));
    check("rst_comc",  32'(COMC), 32'(1'b0));
    rst = 1'b1;
    cyc(4);
    check("post_rst_disp", 32'(disp_7seg), 32'(S1));
    check("post_rst_comc", 32'(COMC), 32'(1'b1));

    // Columns: buttons {P3,P2,P1}, switches {Fc3,Fc2,Fc1}, motor, display.
    add(3'b100, 3'b001, 2'b01, S1);  // 1 -> 3
    add(3'b000, 3'b000, 2'b01, S1);
    add(3'b000, 3'b010, 2'b01, S2);  // passing floor 2
    add(3'b000, 3'b000, 2'b01, S2);
    add(3'b000, 3'b100, 2'b00, S3);  // arrival at 3
    add(3'b001, 3'b100, 2'b10, S3);  // 3 -> 1
    add(3'b000, 3'b000, 2'b10, S3);
    add(3'b000, 3'b010, 2'b10, S2);
    add(3'b000, 3'b000, 2'b10, S2);
    add(3'b000, 3'b001, 2'b00, S1);  // arrival at 1
    add(3'b010, 3'b001, 2'b01, S1);  // 1 -> 2
    add(3'b000, 3'b000, 2'b01, S1);
    add(3'b000, 3'b010, 2'b00, S2);
    add(3'b001, 3'b010, 2'b10, S2);  // 2 -> 1
    add(3'b000, 3'b000, 2'b10, S2);
    add(3'b000, 3'b001, 2'b00, S1);
    add(3'b001, 3'b001, 2'b00, S1);  // request for the current floor
    add(3'b000, 3'b001, 2'b00, S1);
    add(3'b010, 3'b001, 2'b01, S1);  // 1 -> 2
    add(3'b000, 3'b000, 2'b01, S1);
    add(3'b000, 3'b010, 2'b00, S2);
    add(3'b101, 3'b010, 2'b10, S2);  // P1+P3: P1 wins
    add(3'b000, 3'b000, 2'b10, S2);
    add(3'b000, 3'b001, 2'b00, S1);
    add(3'b010, 3'b001, 2'b01, S1);  // target 2 ...
    add(3'b000, 3'b000, 2'b01, S1);
    add(3'b000, 3'b100, 2'b00, S3);  // ... but the top switch stops the cab
    add(3'b001, 3'b100, 2'b10, S3);  // 3 -> 1
    add(3'b100, 3'b000, 2'b10, S3);  // button ignored while moving
    add(3'b000, 3'b001, 2'b00, S1);
    add(3'b000, 3'b011, 2'b00, S1);  // two switches: floor held
    add(3'b000, 3'b001, 2'b00, S1);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].p, vt[i].fc);
      cyc(4);
      check($sformatf("vec%0d_motor", i), 32'(motor), 32'(vt[i].motor));
      check($sformatf("vec%0d_disp", i),  32'(disp_7seg), 32'(vt[i].disp));
    end

    // Exact latency: the motor changes on the 3rd rising edge after the input.
    drive(3'b100, 3'b001);
    cyc(2);
    check("lat_edge2", 32'(motor), 32'(2'b00));
    cyc(1);
    check("lat_edge3", 32'(motor), 32'(2'b01));
    drive(3'b000, 3'b000);
    cyc(4);
    check("travel_up", 32'(motor), 32'(2'b01));

    // Asynchronous reset while travelling: outputs clear before any clock edge.
    #2 rst = 1'b0;
    #1;
    check("async_motor", 32'(motor), 32'(2'b00));
    check("async_comc",  32'(COMC), 32'(1'b0));
    cyc(2);
    rst = 1'b1;
    cyc(4);
    check("unknown_disp", 32'(disp_7seg), 32'(SD));
    drive(3'b010, 3'b000);           // floor unknown: request ignored
    cyc(4);
    check("unknown_motor", 32'(motor), 32'(2'b00));
    check("unknown_disp2", 32'(disp_7seg), 32'(SD));

`ifdef MOVE_TIMEOUT_EN
    drive(3'b000, 3'b001);
    cyc(4);
    drive(3'b100, 3'b001);
    cyc(4);
    check("to_start", 32'(motor), 32'(2'b01));
    drive(3'b000, 3'b000);
    cyc(30);
    check("to_motor", 32'(motor), 32'(2'b00));
    check("to_disp",  32'(disp_7seg), 32'(7'b1001111));
    drive(3'b001, 3'b001);           // FAULT ignores buttons and switches
    cyc(6);
    check("to_hold",  32'(disp_7seg), 32'(7'b1001111));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
